serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial, multi-cycle subtractor: D = A - B - B_IN, processed LSB first, one bit per clock.
//  Inverse counterpart of the parallel adder cell. Used where area matters more than latency.
//  Sits behind a START/DONE handshake in datapath control.
// PARAMETERS
//  WIDTH   10   operand/result width in bits; legal range WIDTH >= 2
// PORTS
//  CLK    in   1      system clock; all state on rising edge
//  RST    in   1      asynchronous, active-high reset
//  START  in   1      request; sampled when in IDLE or DONE, ignored otherwise
//  A      in   WIDTH  minuend, captured on accepted START
//  B      in   WIDTH  subtrahend, captured on accepted START
//  B_IN   in   1      borrow in, captured on accepted START
//  BUSY   out  1      high while bits are being processed
//  DONE   out  1      one-cycle pulse: D, B_OUT and OVF are valid
//  D      out  WIDTH  difference; held until the next accepted START completes
//  B_OUT  out  1      borrow out (1 = unsigned A < B + B_IN)
//  OVF    out  1      signed (two's complement) overflow flag
// BEHAVIOUR
//  - Clock/reset: one clock (CLK); RST is asynchronous and active-high.
//  - Reset values:
//    - State is IDLE.
//    - BUSY=0, DONE=0, D=0, B_OUT=0, OVF=0.
//    - Internal shift registers and counter are cleared.
//  - States: IDLE -> SHIFT -> DONE_S -> IDLE.
//  - IDLE:
//    - On START=1, capture A, B and B_IN into regs a_sh, b_sh and brw.
//    - Clear cnt and go to SHIFT.
//  - SHIFT (BUSY=1), on each edge:
//    - d_bit = a_sh[0] ^ b_sh[0] ^ brw
//    - brw   <= (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw)
//    - a_sh and b_sh shift right by 1; d_sh <= {d_bit, d_sh[WIDTH-1:1]}.
//    - cnt increments. On the edge where cnt == WIDTH-1, go to DONE_S and update the outputs:
//      - D <= final d_sh
//      - B_OUT <= final brw
//      - OVF <= (A_msb != B_msb) && (D_msb != A_msb)
//    - A_msb and B_msb come from a 2-bit sign register captured at START.
//  - DONE_S:
//    - DONE=1 for exactly one cycle; BUSY=0.
//    - If START=1, the new request is accepted (back-to-back) and the next state is SHIFT.
//    - Otherwise the next state is IDLE.
//  - Latency: DONE goes high WIDTH cycles after the accepting edge.
//    - Throughput: one result per WIDTH+1 cycles.
//  - START while in SHIFT: ignored. Operands are not re-sampled and no error is flagged.
//  - Input changes on A/B/B_IN after acceptance: no effect.
//  - D/B_OUT/OVF change only on the final SHIFT edge.
//    - They are stable from DONE until the next completion.
//  - Arithmetic: modulo 2^WIDTH. B_OUT is the unsigned borrow; OVF uses the signed interpretation.
//  - Reset mid-operation: aborts immediately.
//    - All outputs return to their reset values; no DONE pulse.
//  - Counter width: $clog2(WIDTH). Counter never exceeds WIDTH-1.
// STRUCTURE
//  - Shared package holds:
//    - state encoding localparams: ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2
//    - a function computing the counter width
//  - Sub-module full_subtractor_bit (inputs a, b, bin; outputs d, bout):
//    - combinational one-bit cell, instantiated once in the shift loop
//    - mirrors the adder cell convention
//  - Top level holds the FSM, the shift registers, the counter and the output registers.
// TESTING (WIDTH=10 unless noted)
//  1. A=10, B=3, B_IN=0, START pulse -> after 10 cycles DONE=1 with D=7, B_OUT=0, OVF=0.
//     BUSY high for exactly 10 cycles.
//  2. Borrow chain:
//     a. A=3, B=10, B_IN=0 -> D=1017 (0x3F9), B_OUT=1, OVF=0.
//     b. A=5, B=5, B_IN=1 -> D=0x3FF, B_OUT=1.
//  3. Signed overflow: A=0x1FF, B=0x200, B_IN=0 -> D=0x3FF, B_OUT=1, OVF=1.
//     Also A=0x200, B=1 -> D=0x1FF, OVF=1.
//  4. START re-asserted with A=0 during SHIFT -> ignored; original result returned; single DONE.
//     Then START in the DONE cycle with A=8, B=2 -> accepted; D=6 exactly 11 cycles after the first DONE.
//  5. RST asserted asynchronously at cycle 4 of SHIFT:
//     - outputs go to 0 without waiting for a CLK edge
//     - no DONE follows
//     - after release, a new START with A=1, B=1 yields D=0.
//  6. WIDTH=2: exhaustive sweep of all A, B, B_IN (32 cases).
//     D, B_OUT and OVF must match a reference model; latency must be 2 cycles.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings and counter sizing.
package serial_subtractor_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor cell: d = a - b - bin, bout set when a borrow is needed.
module full_subtractor_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor D = A - B - B_IN, LSB first, one bit per clock behind a START/DONE handshake.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = 10
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             B_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] D,
    output logic             B_OUT,
    output logic             OVF
);

    localparam int unsigned CW = cnt_width(WIDTH);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] d_sh;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic [1:0]       sgn;
    logic             d_bit;
    logic             bout_bit;
    logic             last;

    full_subtractor_bit u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (brw),
        .d    (d_bit),
        .bout (bout_bit)
    );

    assign last = (cnt == CW'(WIDTH - 1));
    assign BUSY = (state == ST_SHIFT);
    assign DONE = (state == ST_DONE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            d_sh  <= '0;
            brw   <= 1'b0;
            cnt   <= '0;
            sgn   <= '0;
            D     <= '0;
            B_OUT <= 1'b0;
            OVF   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        brw   <= B_IN;
                        sgn   <= {A[WIDTH-1], B[WIDTH-1]};
                        cnt   <= '0;
                        state <= ST_SHIFT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    brw  <= bout_bit;
                    d_sh <= {d_bit, d_sh[WIDTH-1:1]};
                    // Outputs take the final bit straight from the cell so they update on this same edge.
                    if (last) begin
                        state <= ST_DONE;
                        D     <= {d_bit, d_sh[WIDTH-1:1]};
                        B_OUT <= bout_bit;
                        OVF   <= (sgn[1] != sgn[0]) && (d_bit != sgn[1]);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=10 and WIDTH=2.
module tb_serial_subtractor;

    typedef struct {
        int unsigned d;
        int unsigned bout;
        int unsigned ovf;
        int          cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;

    logic       start10 = 1'b0, bin10 = 1'b0;
    logic [9:0] a10 = '0, b10 = '0;
    logic       busy10, done10, bout10, ovf10;
    logic [9:0] d10;

    logic       start2 = 1'b0, bin2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic       busy2, done2, bout2, ovf2;
    logic [1:0] d2;

    exp_t q10[$];
    exp_t q2[$];

    serial_subtractor #(.WIDTH(10)) dut10 (
        .CLK(clk), .RST(rst), .START(start10), .A(a10), .B(b10), .B_IN(bin10),
        .BUSY(busy10), .DONE(done10), .D(d10), .B_OUT(bout10), .OVF(ovf10)
    );

    serial_subtractor #(.WIDTH(2)) dut2 (
        .CLK(clk), .RST(rst), .START(start2), .A(a2), .B(b2), .B_IN(bin2),
        .BUSY(busy2), .DONE(done2), .D(d2), .B_OUT(bout2), .OVF(ovf2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic exp_t model(input int w, input int a, input int b, input int bin, input int c);
        exp_t e;
        int   full, sa, sb, sres, half;
        half   = 1 << (w - 1);
        full   = a - b - bin;
        e.d    = full & ((1 << w) - 1);
        e.bout = (full < 0) ? 1 : 0;
        sa     = (a >= half) ? a - (1 << w) : a;
        sb     = (b >= half) ? b - (1 << w) : b;
        sres   = sa - sb - bin;
        e.ovf  = (sres < -half || sres > half - 1) ? 1 : 0;
        e.cyc  = c;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && done10) begin
            if (q10.size() == 0) check_eq("spurious_done10", done10, 0);
            else begin
                e = q10.pop_front();
                check_eq("d10", d10, e.d);
                check_eq("bout10", bout10, e.bout);
                check_eq("ovf10", ovf10, e.ovf);
                check_eq("latency10", cyc, e.cyc);
            end
        end
        if (!rst && done2) begin
            if (q2.size() == 0) check_eq("spurious_done2", done2, 0);
            else begin
                e = q2.pop_front();
                check_eq("d2", d2, e.d);
                check_eq("bout2", bout2, e.bout);
                check_eq("ovf2", ovf2, e.ovf);
                check_eq("latency2", cyc, e.cyc);
            end
        end
    end

    task automatic go10(input int a, input int b, input int bin, input bit push);
        @(negedge clk);
        a10 = 10'(a); b10 = 10'(b); bin10 = bin[0]; start10 = 1'b1;
        if (push) q10.push_back(model(10, a, b, bin, cyc + 1 + 10));
        @(negedge clk);
        start10 = 1'b0;
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", busy10, 0);
        check_eq("rst_done", done10, 0);
        check_eq("rst_d", d10, 0);
        check_eq("rst_bout", bout10, 0);
        check_eq("rst_ovf", ovf10, 0);
        rst = 1'b0;

        // Basic subtraction plus BUSY width
        go10(10, 3, 0, 1);
        n = 1;
        for (int i = 0; i < 40 && !done10; i++) begin
            @(negedge clk);
            if (busy10) n++;
        end
        check_eq("busy_cycles", n, 10);
        repeat (2) @(negedge clk);

        go10(3, 10, 0, 1);      repeat (12) @(negedge clk);
        go10(5, 5, 1, 1);       repeat (12) @(negedge clk);
        go10('h1FF, 'h200, 0, 1); repeat (12) @(negedge clk);
        go10('h200, 1, 0, 1);   repeat (12) @(negedge clk);
        go10('h3FF, 'h3FF, 1, 1); repeat (12) @(negedge clk);

        // START during SHIFT is ignored, then back-to-back accept in the DONE cycle
        go10(20, 4, 0, 1);
        repeat (3) @(negedge clk);
        start10 = 1'b1; a10 = '0; b10 = '0;
        repeat (2) @(negedge clk);
        start10 = 1'b0;
        for (int i = 0; i < 30 && !done10; i++) @(negedge clk);
        check_eq("t4_done_seen", done10, 1);
        a10 = 10'd8; b10 = 10'd2; bin10 = 1'b0; start10 = 1'b1;
        q10.push_back(model(10, 8, 2, 0, cyc + 1 + 10));
        @(negedge clk);
        start10 = 1'b0;
        repeat (14) @(negedge clk);
        check_eq("t4_d_held", d10, 6);

        // Asynchronous reset in the middle of SHIFT
        go10(100, 1, 0, 0);
        repeat (3) @(negedge clk);
        check_eq("t5_busy_before", busy10, 1);
        #2 rst = 1'b1;
        #1;
        check_eq("t5_d_async", d10, 0);
        check_eq("t5_busy_async", busy10, 0);
        check_eq("t5_done_async", done10, 0);
        check_eq("t5_bout_async", bout10, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        go10(1, 1, 0, 1);
        repeat (12) @(negedge clk);

        // Exhaustive WIDTH=2 sweep
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int bi = 0; bi < 2; bi++) begin
                    @(negedge clk);
                    a2 = 2'(a); b2 = 2'(b); bin2 = 1'(bi); start2 = 1'b1;
                    q2.push_back(model(2, a, b, bi, cyc + 1 + 2));
                    @(negedge clk);
                    start2 = 1'b0;
                    repeat (2) @(negedge clk);
                end

        for (int i = 0; i < 200 && (q10.size() != 0 || q2.size() != 0); i++) @(negedge clk);
        check_eq("q10_empty", q10.size(), 0);
        check_eq("q2_empty", q2.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
